sweep_sequencer: RTL and testbench
==================================

Name: sweep_sequencer

Overview:
- Frame-level controller for the lighthouse capture datapath. Sits between the lock timer / four capture_center units and the SPI memory/slave path.
- Decodes each sync flash into an axis tag and opens the sweep capture window (sensor mask enable).
- Decides when a sweep frame is complete, then latches the four 16-bit centres into a frame register.
- Publishes the frame to the host with a data_ready/host_ack handshake, with overrun and drop accounting.

Parameters:
- CNT_W, 16, width of the sync pulse-length counter (saturating).
- MIN_PULSE, 16'd1000, shortest sync pulse (clk cycles) accepted; shorter is a glitch.
- AXIS_THRESH, 16'd4700, pulse length at or above which frame_axis=1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- locked  in  1  lock timer locked indication.
- sync_in  in  1  active-high AND of all sensors; high during the sync flash.
- back_porch  in  1  lock timer back-porch flag; sweep window expired.
- cap_ready  in  4  per-sensor ready, bit0=F, 1=C, 2=L, 3=R.
- cap_center  in  64  packed centres: F[15:0], C[31:16], L[47:32], R[63:48].
- host_ack  in  1  one-cycle pulse: host finished reading the published frame.
- mask_en  out  1  enables sensor masks into the capture units.
- clr_ready  out  1  one-cycle pulse: clears capture_center ready flags.
- frame_data  out  64  latched centres, same packing as cap_center.
- frame_valid  out  4  cap_ready snapshot at latch time.
- frame_axis  out  1  axis of the latched frame.
- frame_seq  out  8  sequence number of the latched frame, wraps 255->0.
- data_ready  out  1  a published frame is waiting for host_ack.
- overrun  out  1  sticky flag: a frame was dropped since the last host_ack.
- drop_count  out  8  dropped-frame count, saturates at 255; clears only on reset.

Behaviour:
- Reset (rst_n=0, async):
  - State goes to UNLOCKED.
  - All outputs are 0, including frame_data, frame_seq and drop_count.
  - Internal pulse counter is 0 and the sync_in history flop is 0.
- sync_in edge detection:
  - One history flop, sync_q.
  - rise = sync_in & ~sync_q; fall = ~sync_in & sync_q.
  - The state changes on the clk edge that samples the edge; there are no extra synchronisers (inputs are already registered upstream).
- States:
  - UNLOCKED: mask_en=0. When locked=1 -> WAIT_SYNC.
  - WAIT_SYNC: mask_en=0. On rise -> MEASURE, with plen set to 1.
  - MEASURE:
    - While sync_in=1, plen increments and saturates at all-ones.
    - On fall with plen<MIN_PULSE -> WAIT_SYNC; no clr_ready, no tag change.
    - On fall with plen>=MIN_PULSE: axis_tag <= (plen>=AXIS_THRESH), clr_ready=1 for exactly that cycle, -> SWEEP.
  - SWEEP:
    - mask_en=1, registered; it goes high the cycle after entry and low the cycle after exit.
    - Latch condition: cap_ready==4'hF, or back_porch=1, or rise.
    - On the latch cycle, do the LATCH action (below). Then go to WAIT_SYNC; if the latch was caused by rise, go to MEASURE with plen=1 instead.
- LATCH action, one cycle:
  - If data_ready=0, or host_ack=1 in the same cycle, publish:
    - frame_data lane = cap_center lane where cap_ready bit is 1, else 16'hFFFF.
    - frame_valid <= cap_ready.
    - frame_axis <= axis_tag.
    - frame_seq <= frame_seq+1.
    - data_ready <= 1.
  - Otherwise drop: frame registers unchanged, overrun <= 1, drop_count <= sat(drop_count+1). frame_seq still increments, so the host can detect gaps.
- Handshake:
  - host_ack with data_ready=1 and no simultaneous publish: data_ready <= 0 and overrun <= 0 next cycle.
  - host_ack simultaneous with a publish: the publish wins, data_ready stays 1 with the new frame, and overrun <= 0.
  - host_ack with data_ready=0 is ignored.
- Loss of lock:
  - locked=0 in any state -> UNLOCKED next cycle, with no latch and no clr_ready.
  - data_ready, frame registers and overrun are retained until host_ack.
- Precedence within SWEEP: locked=0, then latch condition, then hold.
- Latency: all-ready (or back_porch) at cycle N gives frame registers and data_ready valid at N+1.

Test Plan:
- Lock, then a sync pulse of 5000 cycles, then cap_ready=F with centres 0x0100/0x0200/0x0300/0x0400 -> clr_ready is one pulse on the fall cycle, mask_en=1 throughout, frame_axis=1, frame_seq=1, frame_valid=F, data_ready=1 one cycle after ready.
- Sync pulse of 2000 cycles, back_porch with cap_ready=4'b0101 -> frame_axis=0, C and R lanes=0xFFFF, frame_valid=5.
- Sync pulse of 500 cycles -> no clr_ready, mask_en stays 0, state returns to WAIT_SYNC.
- Two complete frames with no host_ack -> second frame dropped, frame_data holds frame 1, overrun=1, drop_count=1, frame_seq=2. Then host_ack -> data_ready=0, overrun=0.
- host_ack in the same cycle as a publish -> data_ready remains 1, frame_data is the new frame, overrun=0.
- Drop locked mid-SWEEP -> mask_en=0 next cycle, no publish, data_ready retained. Assert rst_n=0 mid-MEASURE -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/sweep_if.sv
// Bundle between the lighthouse frame sequencer and its surroundings:
// lock/sync/capture status in, frame register and host handshake out.
interface sweep_if;
   logic        locked;
   logic        sync_in;
   logic        back_porch;
   logic [3:0]  cap_ready;
   logic [63:0] cap_center;
   logic        host_ack;
   logic        mask_en;
   logic        clr_ready;
   logic [63:0] frame_data;
   logic [3:0]  frame_valid;
   logic        frame_axis;
   logic [7:0]  frame_seq;
   logic        data_ready;
   logic        overrun;
   logic [7:0]  drop_count;

   modport slave (
      input  locked, sync_in, back_porch, cap_ready, cap_center, host_ack,
      output mask_en, clr_ready, frame_data, frame_valid, frame_axis,
             frame_seq, data_ready, overrun, drop_count
   );

   modport master (
      output locked, sync_in, back_porch, cap_ready, cap_center, host_ack,
      input  mask_en, clr_ready, frame_data, frame_valid, frame_axis,
             frame_seq, data_ready, overrun, drop_count
   );
endinterface

// File: rtl/sweep_sequencer.sv
// Frame-level controller: classifies sync flashes, opens the sweep window,
// latches the four capture centres and hands frames to the host.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// UNLOCKED  | lock timer not locked; nothing happens
// WAIT_SYNC | locked, waiting for the rising edge of a sync flash
// MEASURE   | sync flash in progress, pulse length being counted
// SWEEP     | capture window open (mask_en), waiting for frame complete
module sweep_sequencer #(
   parameter int               CNT_W       = 16,
   parameter logic [CNT_W-1:0] MIN_PULSE   = 16'd1000,
   parameter logic [CNT_W-1:0] AXIS_THRESH = 16'd4700
) (
   input logic       clk,
   input logic       rst_n,
   sweep_if.slave    bus
);

   typedef enum logic [1:0] {
      UNLOCKED  = 2'd0,
      WAIT_SYNC = 2'd1,
      MEASURE   = 2'd2,
      SWEEP     = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             sync_q;
   logic [CNT_W-1:0] plen_q, plen_d;
   logic             axis_q, axis_d;
   logic             mask_en_q;
   logic [63:0]      frame_data_q;
   logic [3:0]       frame_valid_q;
   logic             frame_axis_q;
   logic [7:0]       frame_seq_q;
   logic             data_ready_q;
   logic             overrun_q;
   logic [7:0]       drop_count_q;

   logic        rise, fall;
   logic        clr_ready;
   logic        latch;
   logic        publish;
   logic        drop;
   logic [63:0] lanes;

   assign rise    = bus.sync_in & ~sync_q;
   assign fall    = ~bus.sync_in & sync_q;
   assign publish = latch & (~data_ready_q | bus.host_ack);
   assign drop    = latch & ~publish;

   always_comb begin
      lanes = '0;
      for (int i = 0; i < 4; i++) begin
         lanes[16*i +: 16] = bus.cap_ready[i] ? bus.cap_center[16*i +: 16] : 16'hFFFF;
      end
   end

   always_comb begin
      state_d   = state_q;
      plen_d    = plen_q;
      axis_d    = axis_q;
      clr_ready = 1'b0;
      latch     = 1'b0;
      if (!bus.locked) begin
         state_d = UNLOCKED;
      end else begin
         case (state_q)
            UNLOCKED: state_d = WAIT_SYNC;
            WAIT_SYNC: begin
               if (rise) begin
                  state_d = MEASURE;
                  plen_d  = CNT_W'(1);
               end
            end
            MEASURE: begin
               if (fall) begin
                  if (plen_q < MIN_PULSE) begin
                     state_d = WAIT_SYNC;
                  end else begin
                     axis_d    = (plen_q >= AXIS_THRESH);
                     clr_ready = 1'b1;
                     state_d   = SWEEP;
                  end
               end else if (bus.sync_in && (plen_q != '1)) begin
                  plen_d = plen_q + CNT_W'(1);
               end
            end
            SWEEP: begin
               if ((bus.cap_ready == 4'hF) || bus.back_porch || rise) begin
                  latch = 1'b1;
                  // A new flash closes the frame and is measured straight away
                  if (rise) begin
                     state_d = MEASURE;
                     plen_d  = CNT_W'(1);
                  end else begin
                     state_d = WAIT_SYNC;
                  end
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= UNLOCKED;
         sync_q        <= 1'b0;
         plen_q        <= '0;
         axis_q        <= 1'b0;
         mask_en_q     <= 1'b0;
         frame_data_q  <= '0;
         frame_valid_q <= '0;
         frame_axis_q  <= 1'b0;
         frame_seq_q   <= '0;
         data_ready_q  <= 1'b0;
         overrun_q     <= 1'b0;
         drop_count_q  <= '0;
      end else begin
         state_q   <= state_d;
         sync_q    <= bus.sync_in;
         plen_q    <= plen_d;
         axis_q    <= axis_d;
         mask_en_q <= (state_d == SWEEP);
         if (latch) begin
            frame_seq_q <= frame_seq_q + 8'd1;
         end
         if (publish) begin
            frame_data_q  <= lanes;
            frame_valid_q <= bus.cap_ready;
            frame_axis_q  <= axis_q;
            data_ready_q  <= 1'b1;
            overrun_q     <= 1'b0;
         end else if (bus.host_ack && data_ready_q) begin
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
         end
         if (drop) begin
            overrun_q <= 1'b1;
            if (drop_count_q != 8'hFF) begin
               drop_count_q <= drop_count_q + 8'd1;
            end
         end
      end
   end

   assign bus.mask_en     = mask_en_q;
   assign bus.clr_ready   = clr_ready;
   assign bus.frame_data  = frame_data_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_axis  = frame_axis_q;
   assign bus.frame_seq   = frame_seq_q;
   assign bus.data_ready  = data_ready_q;
   assign bus.overrun     = overrun_q;
   assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: expected frames are queued as each
// latch is provoked and checked by a monitor whenever frame_seq moves.
module tb_sweep_sequencer;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   sweep_if bus ();

   sweep_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [3:0]  valid;
      logic        axis;
      logic [7:0]  seq;
      logic        dr;
      logic        ov;
      logic [7:0]  drop;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] prev_seq = 8'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic push_exp(input logic [63:0] data, input logic [3:0] valid, input logic axis,
                           input logic [7:0] seq, input logic dr, input logic ov,
                           input logic [7:0] drop);
      exp_t e;
      e.data  = data;
      e.valid = valid;
      e.axis  = axis;
      e.seq   = seq;
      e.dr    = dr;
      e.ov    = ov;
      e.drop  = drop;
      exp_q.push_back(e);
   endtask

   // Sync flash of len cycles; accept says whether it should open a sweep.
   task automatic pulse(input int len, input logic accept);
      bus.sync_in = 1'b1;
      ticks(len);
      bus.sync_in = 1'b0;
      @(negedge clk);
      chk("clr_ready_on_fall", 64'(bus.clr_ready), 64'(accept));
      tick();
      @(negedge clk);
      chk("clr_ready_single", 64'(bus.clr_ready), 64'(0));
      chk("mask_en_after_sync", 64'(bus.mask_en), 64'(accept));
      tick();
      if (accept) chk("mask_en_in_sweep", 64'(bus.mask_en), 64'(1));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_mask_en"},     64'(bus.mask_en),     64'(0));
      chk({tag, "_clr_ready"},   64'(bus.clr_ready),   64'(0));
      chk({tag, "_frame_data"},  bus.frame_data,       64'(0));
      chk({tag, "_frame_valid"}, 64'(bus.frame_valid), 64'(0));
      chk({tag, "_frame_axis"},  64'(bus.frame_axis),  64'(0));
      chk({tag, "_frame_seq"},   64'(bus.frame_seq),   64'(0));
      chk({tag, "_data_ready"},  64'(bus.data_ready),  64'(0));
      chk({tag, "_overrun"},     64'(bus.overrun),     64'(0));
      chk({tag, "_drop_count"},  64'(bus.drop_count),  64'(0));
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_seq = bus.frame_seq;
      end else if (bus.frame_seq !== prev_seq) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got seq %0d expected no frame", bus.frame_seq);
         end else begin
            mon_e = exp_q.pop_front();
            chk("frame_data",  bus.frame_data,        mon_e.data);
            chk("frame_valid", 64'(bus.frame_valid),  64'(mon_e.valid));
            chk("frame_axis",  64'(bus.frame_axis),   64'(mon_e.axis));
            chk("frame_seq",   64'(bus.frame_seq),    64'(mon_e.seq));
            chk("data_ready",  64'(bus.data_ready),   64'(mon_e.dr));
            chk("overrun",     64'(bus.overrun),      64'(mon_e.ov));
            chk("drop_count",  64'(bus.drop_count),   64'(mon_e.drop));
         end
         prev_seq = bus.frame_seq;
      end
   end

   initial begin
      bus.locked     = 1'b0;
      bus.sync_in    = 1'b0;
      bus.back_porch = 1'b0;
      bus.cap_ready  = 4'h0;
      bus.cap_center = 64'h0;
      bus.host_ack   = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #5 check_all_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.locked = 1'b1;
      ticks(2);

      // Frame 1: long flash -> axis 1, all four sensors ready
      pulse(5000, 1'b1);
      bus.cap_center = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
      bus.cap_ready  = 4'hF;
      push_exp({16'h0400, 16'h0300, 16'h0200, 16'h0100}, 4'hF, 1'b1, 8'd1, 1'b1, 1'b0, 8'd0);
      tick();
      bus.cap_ready = 4'h0;
      @(negedge clk);
      chk("f1_data_ready_next", 64'(bus.data_ready), 64'(1));
      chk("f1_mask_en_off", 64'(bus.mask_en), 64'(0));
      tick();
      bus.host_ack = 1'b1;
      tick();
      bus.host_ack = 1'b0;
      @(negedge clk);
      chk("f1_ack_data_ready", 64'(bus.data_ready), 64'(0));
      tick();

      // Frame 2: short flash -> axis 0, back_porch with partial ready
      pulse(2000, 1'b1);
      bus.cap_center = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
      bus.cap_ready  = 4'b0101;
      bus.back_porch = 1'b1;
      push_exp({16'hFFFF, 16'hBBBB, 16'hFFFF, 16'hDDDD}, 4'h5, 1'b0, 8'd2, 1'b1, 1'b0, 8'd0);
      tick();
      bus.back_porch = 1'b0;
      bus.cap_ready  = 4'h0;
      @(negedge clk);
      chk("f2_data_ready", 64'(bus.data_ready), 64'(1));
      tick();
      bus.host_ack = 1'b1;
      tick();
      bus.host_ack = 1'b0;
      @(negedge clk);
      chk("f2_ack_data_ready", 64'(bus.data_ready), 64'(0));
      tick();

      // Glitches: rejected without clr_ready or mask_en
      pulse(500, 1'b0);
      pulse(999, 1'b0);
      @(negedge clk);
      chk("glitch_seq_held", 64'(bus.frame_seq), 64'(2));
      tick();

      // Frame A at exact axis threshold published, frame B at exact MIN_PULSE dropped
      pulse(4700, 1'b1);
      bus.cap_center = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      bus.cap_ready  = 4'hF;
      push_exp({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'hF, 1'b1, 8'd3, 1'b1, 1'b0, 8'd0);
      tick();
      bus.cap_ready = 4'h0;
      ticks(2);
      pulse(1000, 1'b1);
      bus.cap_center = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
      bus.cap_ready  = 4'hF;
      push_exp({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'hF, 1'b1, 8'd4, 1'b1, 1'b1, 8'd1);
      tick();
      bus.cap_ready = 4'h0;
      tick();
      bus.host_ack = 1'b1;
      tick();
      bus.host_ack = 1'b0;
      @(negedge clk);
      chk("drop_ack_data_ready", 64'(bus.data_ready), 64'(0));
      chk("drop_ack_overrun", 64'(bus.overrun), 64'(0));
      tick();

      // Frame C published, D dropped by the next flash, E published with same-cycle ack
      pulse(1100, 1'b1);
      bus.cap_center = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
      bus.cap_ready  = 4'hF;
      push_exp({16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A}, 4'hF, 1'b0, 8'd5, 1'b1, 1'b0, 8'd1);
      tick();
      bus.cap_ready = 4'h0;
      tick();
      pulse(4800, 1'b1);
      bus.cap_ready = 4'b0011;
      push_exp({16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A}, 4'hF, 1'b0, 8'd6, 1'b1, 1'b1, 8'd2);
      pulse(4699, 1'b1);
      bus.cap_center = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
      bus.cap_ready  = 4'hF;
      bus.host_ack   = 1'b1;
      push_exp({16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 4'hF, 1'b0, 8'd7, 1'b1, 1'b0, 8'd2);
      tick();
      bus.host_ack  = 1'b0;
      bus.cap_ready = 4'h0;
      @(negedge clk);
      chk("ack_publish_data_ready", 64'(bus.data_ready), 64'(1));
      tick();

      // Lock lost mid-sweep while all sensors report ready: no latch
      pulse(1500, 1'b1);
      bus.locked    = 1'b0;
      bus.cap_ready = 4'hF;
      tick();
      bus.cap_ready = 4'h0;
      @(negedge clk);
      chk("unlock_mask_en", 64'(bus.mask_en), 64'(0));
      chk("unlock_data_ready", 64'(bus.data_ready), 64'(1));
      chk("unlock_seq", 64'(bus.frame_seq), 64'(7));
      chk("unlock_frame_data", bus.frame_data, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0});
      tick();
      bus.locked = 1'b1;
      ticks(2);

      // Async reset in the middle of a flash measurement
      bus.sync_in = 1'b1;
      ticks(100);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      bus.sync_in = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      ticks(3);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
